ps2_rx_periph: RTL

- Memory-mapped PS/2 keyboard receiver that acts as a responder on the calculator controller's data bus (data_sel/data_we/data_addr/data_to_wr/data_to_rd).
- Deserialises PS/2 device-to-host frames and buffers received scan codes in a FIFO.
- Exposes status, data, control and count registers that the controller reads and writes with RDW/WRW.
- Sits beside the register file and is selected by the top-level address decode.

---
 rtl/ps2_rx_periph_if.sv | 23 ++
 rtl/ps2_rx_periph.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_periph_if.sv
`default_nettype none
// ps2_rx_periph_if -- controller data-bus bundle for the PS/2 receiver peripheral.
// Rev 1.0 -- initial release.
interface ps2_rx_periph_if #(
  parameter int DATA_W = 32
);
  logic              data_sel;
  logic              data_we;
  logic [1:0]        data_addr;
  logic [DATA_W-1:0] data_to_wr;
  logic [DATA_W-1:0] data_to_rd;

  modport master (
    output data_sel, data_we, data_addr, data_to_wr,
    input  data_to_rd
  );

  modport slave (
    input  data_sel, data_we, data_addr, data_to_wr,
    output data_to_rd
  );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_periph.sv
`default_nettype none
// ps2_rx_periph -- memory-mapped PS/2 keyboard receiver with scan-code FIFO.
// Rev 1.0 -- optional interrupt output enabled by defining PS2_IRQ_EN.
module ps2_rx_periph #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_rx_periph_if.slave bus,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  output logic           irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0]    ADDR_STATUS = 2'd0;
  localparam logic [1:0]    ADDR_DATA   = 2'd1;
  localparam logic [1:0]    ADDR_CTRL   = 2'd2;
  localparam logic [1:0]    ADDR_COUNT  = 2'd3;
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   fall_q, fall_d;
  logic                   bit_q, bit_d;

  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   push_req;
  logic                   frame_err_set;

  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [7:0]             mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [AW-1:0]          rptr_q, rptr_d;
  logic [CW-1:0]          count_q, count_d;

  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;
  logic                   rx_en_q, rx_en_d;
  logic                   irq_en;

  logic                   wr_en, rd_en, wr_status, wr_ctrl;
  logic                   not_empty, full, pop, push_ok, ovf_set;
  logic [DATA_W-1:0]      rd_data;
  logic                   unused_wr;

  // Synchronisers plus a registered edge detector; the data line is sampled
  // in the same cycle the falling edge is registered.
  always_comb begin
    clk_sync_d = (clk_sync_q << 1) | SYNC_STAGES'(ps2_clk);
    dat_sync_d = (dat_sync_q << 1) | SYNC_STAGES'(ps2_data);
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    fall_d     = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    bit_d      = dat_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    to_cnt_d      = to_cnt_q;
    push_req      = 1'b0;
    frame_err_set = 1'b0;

    if (state_q == ST_IDLE || fall_q) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d = '0;
      state_d  = ST_IDLE;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    if (fall_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!bit_q && rx_en_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {bit_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = bit_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          if (bit_q && (^{shift_q, parity_q})) push_req = 1'b1;
          else                                 frame_err_set = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign wr_en     = bus.data_sel & bus.data_we;
  assign rd_en     = bus.data_sel & ~bus.data_we;
  assign wr_status = wr_en & (bus.data_addr == ADDR_STATUS);
  assign wr_ctrl   = wr_en & (bus.data_addr == ADDR_CTRL);
  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_FULL);
  assign pop       = rd_en & (bus.data_addr == ADDR_DATA) & not_empty;
  // Fullness is judged before this cycle's pop, so a push into a full FIFO drops.
  assign push_ok   = push_req & ~full;
  assign ovf_set   = push_req & full;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop);
    if (push_ok) begin
      mem_d[wptr_q] = shift_q;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);

    overflow_d  = (overflow_q  & ~(wr_status & bus.data_to_wr[2])) | ovf_set;
    frame_err_d = (frame_err_q & ~(wr_status & bus.data_to_wr[3])) | frame_err_set;
    rx_en_d     = wr_ctrl ? bus.data_to_wr[0] : rx_en_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '0;
      dat_sync_q  <= '0;
      clk_prev_q  <= 1'b0;
      fall_q      <= 1'b0;
      bit_q       <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      mem_q       <= '{default: 8'h00};
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_en_q     <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_prev_q  <= clk_prev_d;
      fall_q      <= fall_d;
      bit_q       <= bit_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      rx_en_q     <= rx_en_d;
    end
  end

`ifdef PS2_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  // Built from next-state values so irq tracks irq_en & not_empty with no lag.
  always_comb begin
    irq_en_d = wr_ctrl ? bus.data_to_wr[1] : irq_en_q;
    irq_d    = irq_en_d & (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (bus.data_sel) begin
      unique case (bus.data_addr)
        ADDR_STATUS: rd_data[3:0]    = {frame_err_q, overflow_q, full, not_empty};
        ADDR_DATA:   rd_data[7:0]    = not_empty ? mem_q[rptr_q] : 8'h00;
        ADDR_CTRL:   rd_data[1:0]    = {irq_en, rx_en_q};
        ADDR_COUNT:  rd_data[CW-1:0] = count_q;
        default:     rd_data         = '0;
      endcase
    end
  end

  assign bus.data_to_rd = rd_data;
  assign unused_wr      = ^bus.data_to_wr;

endmodule
`default_nettype wire
